// File: rtl/seq_classifier_if.sv
// Parameter-store write port plus start/busy/done result handshake of seq_classifier.
interface seq_classifier_if #(
   parameter int M  = 11,
   parameter int K  = 4,
   parameter int H  = 2,
   parameter int C  = 6,
   parameter int W  = 8,
   parameter int HA = 16
);
   localparam int D  = H*M + H + C*H + C;
   localparam int AW = $clog2(D);
   localparam int SW = HA + W + $clog2(H) + 2;
   localparam int CW = $clog2(C+1);

   logic                 param_we;
   logic [AW-1:0]        param_addr;
   logic signed [W-1:0]  param_data;
   logic                 start;
   logic [M*K-1:0]       act_in;
   logic                 busy;
   logic                 done;
   logic [CW-1:0]        class_out;
   logic signed [SW-1:0] score_out;

   modport master (
      output param_we, param_addr, param_data, start, act_in,
      input  busy, done, class_out, score_out
   );

   modport slave (
      input  param_we, param_addr, param_data, start, act_in,
      output busy, done, class_out, score_out
   );
endinterface

// File: rtl/seq_classifier.sv
// Two-layer integer classifier (ReLU hidden layer, signed argmax) on one shared MAC.
// Latency H*(M+1)+C*(H+1)+1 cycles start-to-done; start and store writes are ignored while busy.
module seq_classifier #(
   parameter int M  = 11,
   parameter int K  = 4,
   parameter int H  = 2,
   parameter int C  = 6,
   parameter int W  = 8,
   parameter int HA = 16
) (
   input logic        clk,
   input logic        rst,
   seq_classifier_if.slave bus
);
   localparam int D   = H*M + H + C*H + C;
   localparam int AW  = $clog2(D);
   localparam int SW  = HA + W + $clog2(H) + 2;
   localparam int CW  = $clog2(C+1);
   localparam int IW  = $clog2(M+1);
   localparam int NW  = $clog2((H > C ? H : C) + 1);
   localparam int HIW = (H > 1) ? $clog2(H) : 1;
   localparam int HB  = H*M;
   localparam int OW  = H*M + H;
   localparam int OB  = H*M + H + C*H;

   typedef enum logic [1:0] {IDLE, HID, OUT, FIN} state_t;

   state_t               state_q, state_d;
   logic [IW-1:0]        i_q, i_d;
   logic [NW-1:0]        n_q, n_d;
   logic [M*K-1:0]       act_q, act_d;
   logic signed [SW-1:0] acc_q, acc_d;
   logic signed [SW-1:0] best_q, best_d;
   logic [CW-1:0]        best_idx_q, best_idx_d;
   logic [CW-1:0]        class_q, class_d;
   logic signed [SW-1:0] score_q, score_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [HA-1:0]        hid_q [H];
   logic [HA-1:0]        hid_d [H];
   logic signed [W-1:0]  store_q [D];

   int                   addr_int;
   logic [AW-1:0]        rd_addr;
   logic signed [SW-1:0] mul_a, mul_b, prod, fin;

   // Single read port: the FSM position alone selects the weight or bias in use.
   always_comb begin
      addr_int = 0;
      mul_a    = '0;
      case (state_q)
         HID: begin
            if (i_q < IW'(M)) begin
               addr_int = int'(n_q)*M + int'(i_q);
               mul_a    = SW'(act_q[i_q*K +: K]);
            end else begin
               addr_int = HB + int'(n_q);
            end
         end
         OUT: begin
            if (i_q < IW'(H)) begin
               addr_int = OW + int'(n_q)*H + int'(i_q);
               mul_a    = SW'(hid_q[HIW'(i_q)]);
            end else begin
               addr_int = OB + int'(n_q);
            end
         end
         default: ;
      endcase
      rd_addr = AW'(addr_int);
      mul_b   = SW'(store_q[rd_addr]);
      prod    = mul_a * mul_b;
      fin     = acc_q + mul_b;
   end

   always_comb begin
      state_d    = state_q;
      i_d        = i_q;
      n_d        = n_q;
      act_d      = act_q;
      acc_d      = acc_q;
      best_d     = best_q;
      best_idx_d = best_idx_q;
      class_d    = class_q;
      score_d    = score_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      hid_d      = hid_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               act_d   = bus.act_in;
               acc_d   = '0;
               i_d     = '0;
               n_d     = '0;
               busy_d  = 1'b1;
               state_d = HID;
            end
         end
         HID: begin
            if (i_q < IW'(M)) begin
               acc_d = acc_q + prod;
               i_d   = i_q + 1'b1;
            end else begin
               // ReLU below zero, clamp to all-ones above the activation range
               if (fin[SW-1])            hid_d[HIW'(n_q)] = '0;
               else if (|fin[SW-2:HA])   hid_d[HIW'(n_q)] = '1;
               else                      hid_d[HIW'(n_q)] = fin[HA-1:0];
               acc_d = '0;
               i_d   = '0;
               if (n_q == NW'(H-1)) begin
                  n_d     = '0;
                  state_d = OUT;
               end else begin
                  n_d = n_q + 1'b1;
               end
            end
         end
         OUT: begin
            if (i_q < IW'(H)) begin
               acc_d = acc_q + prod;
               i_d   = i_q + 1'b1;
            end else begin
               // strict compare so ties keep the lowest class
               if (n_q == '0 || fin > best_q) begin
                  best_d     = fin;
                  best_idx_d = CW'(n_q);
               end
               acc_d = '0;
               i_d   = '0;
               if (n_q == NW'(C-1)) state_d = FIN;
               else                 n_d = n_q + 1'b1;
            end
         end
         FIN: begin
            class_d = best_idx_q + 1'b1;
            score_d = best_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         i_q        <= '0;
         n_q        <= '0;
         act_q      <= '0;
         acc_q      <= '0;
         best_q     <= '0;
         best_idx_q <= '0;
         class_q    <= '0;
         score_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         for (int h = 0; h < H; h++) hid_q[h] <= '0;
      end else begin
         state_q    <= state_d;
         i_q        <= i_d;
         n_q        <= n_d;
         act_q      <= act_d;
         acc_q      <= acc_d;
         best_q     <= best_d;
         best_idx_q <= best_idx_d;
         class_q    <= class_d;
         score_q    <= score_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         for (int h = 0; h < H; h++) hid_q[h] <= hid_d[h];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int a = 0; a < D; a++) store_q[a] <= '0;
      end else if (bus.param_we && !busy_q && int'(bus.param_addr) < D) begin
         store_q[bus.param_addr] <= bus.param_data;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.class_out = class_q;
   assign bus.score_out = score_q;
endmodule

// File: tb/tb_seq_classifier.sv
// Directed bench for seq_classifier: default instance plus an HA=8 copy sharing all inputs.
module tb_seq_classifier;
   localparam int M = 11, K = 4, H = 2, C = 6, W = 8;
   localparam int AW = 6;

   logic clk, rst;
   logic param_we, start;
   logic [AW-1:0] param_addr;
   logic signed [W-1:0] param_data;
   logic [M*K-1:0] act_in;

   int checks = 0;
   int failures = 0;

   seq_classifier_if #(.M(M), .K(K), .H(H), .C(C), .W(W), .HA(16)) a_if ();
   seq_classifier_if #(.M(M), .K(K), .H(H), .C(C), .W(W), .HA(8))  b_if ();

   assign a_if.param_we = param_we;   assign b_if.param_we = param_we;
   assign a_if.param_addr = param_addr; assign b_if.param_addr = param_addr;
   assign a_if.param_data = param_data; assign b_if.param_data = param_data;
   assign a_if.start = start;         assign b_if.start = start;
   assign a_if.act_in = act_in;       assign b_if.act_in = act_in;

   seq_classifier #(.M(M), .K(K), .H(H), .C(C), .W(W), .HA(16)) u_a (
      .clk(clk), .rst(rst), .bus(a_if.slave));
   seq_classifier #(.M(M), .K(K), .H(H), .C(C), .W(W), .HA(8)) u_b (
      .clk(clk), .rst(rst), .bus(b_if.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // results captured by run()
   int n_done, d1, d2, cls1, clsb, hold_cls;
   longint scr1, scrb;
   logic busy0, busy41, busy_at_done;
   logic rst_busy, rst_done;
   int rst_cls;
   longint rst_scr;

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic wr(input int addr, input int val);
      param_we   = 1'b1;
      param_addr = AW'(addr);
      param_data = W'(val);
      @(negedge clk);
      param_we   = 1'b0;
   endtask

   // cyc counts negedges after the edge that samples start; window bounds every wait
   task automatic run(input int restart_cyc, input int wr_cyc, input int rst_cyc, input bit b2b);
      n_done = 0; d1 = -1; d2 = -1; cls1 = -1; clsb = -1; scr1 = -999; scrb = -999;
      busy0 = 1'b0; busy41 = 1'b0; busy_at_done = 1'b1;
      rst_busy = 1'bx; rst_done = 1'bx; rst_cls = -1; rst_scr = -999;
      start = 1'b1;
      @(negedge clk);
      for (int cyc = 0; cyc < 100; cyc++) begin
         if (cyc > 0) @(negedge clk);
         start    = 1'b0;
         param_we = 1'b0;
         if (cyc == 0)  busy0  = a_if.busy;
         if (cyc == 41) busy41 = a_if.busy;
         if (a_if.done) begin
            n_done++;
            if (d1 < 0) begin
               d1 = cyc; busy_at_done = a_if.busy;
               cls1 = int'(a_if.class_out); scr1 = a_if.score_out;
               clsb = int'(b_if.class_out); scrb = b_if.score_out;
               if (b2b) start = 1'b1;
            end else begin
               d2 = cyc;
            end
         end
         if (cyc == restart_cyc) start = 1'b1;
         if (cyc == wr_cyc) begin
            param_we = 1'b1; param_addr = AW'(39); param_data = W'(-50);
         end
         if (cyc == rst_cyc) begin
            rst = 1'b1;
            #1;
            rst_busy = a_if.busy; rst_done = a_if.done;
            rst_cls = int'(a_if.class_out); rst_scr = a_if.score_out;
         end
         if (cyc == rst_cyc + 2) rst = 1'b0;
         hold_cls = int'(a_if.class_out);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; param_we = 1'b0; param_addr = '0; param_data = '0; act_in = '0;
      do_reset();
      chk("reset_busy",  longint'(a_if.busy), 0);
      chk("reset_done",  longint'(a_if.done), 0);
      chk("reset_class", longint'(a_if.class_out), 0);
      chk("reset_score", longint'(a_if.score_out), 0);

      // empty store
      run(-1, -1, -1, 1'b0);
      chk("empty_class", cls1, 1);
      chk("empty_score", scr1, 0);

      // single output bias, latency and busy shape
      do_reset();
      wr(39, 5);
      act_in = {M*K{1'b1}};
      run(-1, -1, -1, 1'b0);
      chk("obias_latency", d1, 43);
      chk("obias_class", cls1, 4);
      chk("obias_score", scr1, 5);
      chk("obias_ndone", n_done, 1);
      chk("obias_busy_c0", longint'(busy0), 1);
      chk("obias_busy_c41", longint'(busy41), 1);
      chk("obias_busy_done", longint'(busy_at_done), 0);
      chk("obias_hold", hold_cls, 4);

      // one hidden path
      do_reset();
      act_in = '0; act_in[3:0] = 4'd15;
      wr(0, 1);
      wr(26, 2);
      run(-1, -1, -1, 1'b0);
      chk("hid_class", cls1, 2);
      chk("hid_score", scr1, 30);

      // ReLU kills hidden neuron, then negative output biases
      do_reset();
      wr(22, -100);
      wr(0, 1);
      run(-1, -1, -1, 1'b0);
      chk("relu_class", cls1, 1);
      chk("relu_score", scr1, 0);
      for (int c = 0; c < 5; c++) wr(36 + c, -3);
      wr(41, -1);
      run(-1, -1, -1, 1'b0);
      chk("neg_class", cls1, 6);
      chk("neg_score", scr1, -1);

      // tie keeps lowest class
      do_reset();
      wr(38, 7);
      wr(40, 7);
      run(-1, -1, -1, 1'b0);
      chk("tie_class", cls1, 3);
      chk("tie_score", scr1, 7);

      // saturation (HA=8 copy) vs unsaturated default
      do_reset();
      act_in = {M*K{1'b1}};
      for (int i = 0; i < M; i++) wr(i, 127);
      wr(24, 1);
      run(-1, -1, -1, 1'b0);
      chk("sat_b_class", clsb, 1);
      chk("sat_b_score", scrb, 255);
      chk("sat_a_class", cls1, 1);
      chk("sat_a_score", scr1, 20955);

      // start while busy ignored
      do_reset();
      wr(39, 5);
      run(10, -1, -1, 1'b0);
      chk("restart_ndone", n_done, 1);
      chk("restart_latency", d1, 43);

      // writes while busy ignored
      run(-1, 5, -1, 1'b0);
      chk("wrbusy_class", cls1, 4);
      chk("wrbusy_score", scr1, 5);
      run(-1, -1, -1, 1'b0);
      chk("wrbusy_after_class", cls1, 4);
      chk("wrbusy_after_score", scr1, 5);

      // back-to-back start in the done cycle
      run(-1, -1, -1, 1'b1);
      chk("b2b_first", d1, 43);
      chk("b2b_second", d2, 87);
      chk("b2b_ndone", n_done, 2);

      // reset mid-inference
      run(-1, -1, 20, 1'b0);
      chk("rst_busy", longint'(rst_busy), 0);
      chk("rst_done", longint'(rst_done), 0);
      chk("rst_class", rst_cls, 0);
      chk("rst_score", rst_scr, 0);
      chk("rst_ndone", n_done, 0);
      chk("rst_hold", hold_cls, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
